// File: rtl/storage_wb_bridge_if.sv
// storage_wb_bridge_if: Wishbone slave bus bundle; wbs_err_o exists only when STORAGE_WB_ERR_EN is defined
interface storage_wb_bridge_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
`ifdef STORAGE_WB_ERR_EN
  logic        wbs_err_o;
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o, wbs_err_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o, wbs_err_o
  );
`else
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
`endif
endinterface

// File: rtl/storage_wb_bridge.sv
// storage_wb_bridge: Wishbone slave driving the mgmt R/W port of up to 8 banks of 512x32 SRAM
// STORAGE_WB_ERR_EN: out-of-range banks answer with wbs_err_o instead of an ack
module storage_wb_bridge #(
  parameter int          BLOCKS    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_C000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  storage_wb_bridge_if.slave    wb,
  output logic [BLOCKS-1:0]     mem_ena,
  output logic [BLOCKS-1:0]     mem_wen,
  output logic [BLOCKS*4-1:0]   mem_wen_mask,
  output logic [8:0]            mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [BLOCKS*32-1:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, ACK} state_t;
  state_t state_q, state_d;
  logic [2:0] bank_q, bank_d;
  logic we_q, we_d, oor_q, oor_d;
  logic [BLOCKS-1:0] ena_q, ena_d, wen_q, wen_d;
  logic [BLOCKS*4-1:0] mask_q, mask_d;
  logic [8:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, dat_q, dat_d;
  logic ack_q, ack_d;
`ifdef STORAGE_WB_ERR_EN
  logic err_q, err_d;
`endif
  logic hit, req_oor, no_write;
  logic [2:0] req_bank;
  logic [BLOCKS-1:0] req_sel;
  logic [BLOCKS*4-1:0] lane_mask;
  logic [255:0] rd_all;
  assign hit       = wb.wbs_cyc_i & wb.wbs_stb_i & ((wb.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign req_bank  = wb.wbs_adr_i[13:11];
  assign req_oor   = 32'(req_bank) >= 32'(BLOCKS);
  assign req_sel   = BLOCKS'(1) << req_bank;
  assign lane_mask = (BLOCKS*4)'(wb.wbs_sel_i) << {req_bank, 2'b00};
  assign no_write  = req_oor | ~wb.wbs_we_i;
  assign rd_all    = 256'(mem_rdata);
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    oor_d   = oor_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dat_d   = dat_q;
    ena_d   = '1;
    wen_d   = '1;
    mask_d  = '0;
    ack_d   = 1'b0;
`ifdef STORAGE_WB_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (hit) begin
        state_d = ACCESS;
        bank_d  = req_bank;
        we_d    = wb.wbs_we_i;
        oor_d   = req_oor;
        addr_d  = wb.wbs_adr_i[10:2];
        wdata_d = wb.wbs_dat_i;
        ena_d   = req_oor ? '1 : ~req_sel;
        wen_d   = no_write ? '1 : ~req_sel;
        mask_d  = no_write ? '0 : lane_mask;
      end
      ACCESS: begin
        state_d = !wb.wbs_cyc_i ? IDLE : (we_q || oor_q) ? ACK : RDWAIT;
`ifdef STORAGE_WB_ERR_EN
        ack_d   = wb.wbs_cyc_i & we_q & ~oor_q;
        err_d   = wb.wbs_cyc_i & oor_q;
`else
        // out-of-range banks are acked; reads of them return zero
        ack_d   = wb.wbs_cyc_i & (we_q | oor_q);
        dat_d   = (wb.wbs_cyc_i && oor_q && !we_q) ? '0 : dat_q;
`endif
      end
      RDWAIT: begin
        state_d = wb.wbs_cyc_i ? ACK : IDLE;
        ack_d   = wb.wbs_cyc_i;
        dat_d   = wb.wbs_cyc_i ? rd_all[{bank_q, 5'b0} +: 32] : dat_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      bank_q  <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dat_q   <= '0;
      ena_q   <= '1;
      wen_q   <= '1;
      mask_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dat_q   <= dat_d;
      ena_q   <= ena_d;
      wen_q   <= wen_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
    end
  end
`ifdef STORAGE_WB_ERR_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign wb.wbs_err_o = err_q;
`endif
  assign wb.wbs_ack_o   = ack_q;
  assign wb.wbs_dat_o   = dat_q;
  assign mem_ena        = ena_q;
  assign mem_wen        = wen_q;
  assign mem_wen_mask   = mask_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
endmodule

// File: tb/tb_storage_wb_bridge.sv
// tb_storage_wb_bridge: directed plus randomized Wishbone traffic checked against a transaction-level memory model
module tb_storage_wb_bridge;
  localparam int BLOCKS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  storage_wb_bridge_if wb();
  logic [BLOCKS-1:0]    mem_ena, mem_wen;
  logic [BLOCKS*4-1:0]  mem_wen_mask;
  logic [8:0]           mem_addr;
  logic [31:0]          mem_wdata;
  logic [BLOCKS*32-1:0] mem_rdata;
  logic                 err_o;
  storage_wb_bridge #(.BLOCKS(BLOCKS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb),
    .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_wen_mask(mem_wen_mask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
`ifdef STORAGE_WB_ERR_EN
  assign err_o = wb.wbs_err_o;
`else
  assign err_o = 1'b0;
`endif
  // SRAM banks: synchronous, active-low select/write, byte-masked writes
  for (genvar g = 0; g < BLOCKS; g++) begin : g_bank
    logic [31:0] mem [512] = '{default: '0};
    logic [31:0] rdq = '0;
    always @(posedge clk)
      if (!mem_ena[g]) begin
        if (!mem_wen[g])
          mem[mem_addr] <= {mem_wen_mask[g*4+3] ? mem_wdata[31:24] : mem[mem_addr][31:24],
                            mem_wen_mask[g*4+2] ? mem_wdata[23:16] : mem[mem_addr][23:16],
                            mem_wen_mask[g*4+1] ? mem_wdata[15:8]  : mem[mem_addr][15:8],
                            mem_wen_mask[g*4+0] ? mem_wdata[7:0]   : mem[mem_addr][7:0]};
        rdq <= mem[mem_addr];
      end
    assign mem_rdata[g*32 +: 32] = rdq;
  end
  int acc_cnt = 0, ack_cnt = 0, err_cnt = 0;
  logic [BLOCKS-1:0] last_ena, last_wen;
  logic [BLOCKS*4-1:0] last_mask;
  logic [8:0] last_addr;
  logic [31:0] last_wdata;
  always @(negedge clk) begin
    if (mem_ena != '1) begin
      acc_cnt    <= acc_cnt + 1;
      last_ena   <= mem_ena;
      last_wen   <= mem_wen;
      last_mask  <= mem_wen_mask;
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (wb.wbs_ack_o) ack_cnt <= ack_cnt + 1;
    if (err_o) err_cnt <= err_cnt + 1;
  end
  logic [31:0] ref_mem [BLOCKS][512] = '{default: '{default: '0}};
  logic [31:0] exp_dat = '0;
  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                     input logic hold, output int lat, output logic [31:0] rd, output int acc, output int acks, output int errs);
    int a0, k0, e0;
    a0 = acc_cnt; k0 = ack_cnt; e0 = err_cnt;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_sel_i = sel; wb.wbs_adr_i = adr; wb.wbs_dat_i = dat;
    lat = -1;
    rd = 'x;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb.wbs_ack_o || err_o) begin
        lat = i;
        rd = wb.wbs_dat_o;
      end
    end
    @(posedge clk); #1;
    if (!hold) begin
      wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    acc = acc_cnt - a0; acks = ack_cnt - k0; errs = err_cnt - e0;
  endtask
  task automatic run(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat, input logic hold);
    int lat, acc, acks, errs, bank, word;
    logic [31:0] rd;
    logic in_win, oor;
    logic [BLOCKS-1:0] exp_ena, exp_wen;
    logic [BLOCKS*4-1:0] exp_mask;
    in_win = adr[31:14] == 18'h0C000;
    bank = int'(adr[13:11]);
    word = int'(adr[10:2]);
    oor = in_win && bank >= BLOCKS;
    txn(we, sel, adr, dat, hold, lat, rd, acc, acks, errs);
    if (!in_win) begin
      check("miss_lat", 64'(lat), 64'(-1));
      check("miss_acc", 64'(acc), 64'(0));
      check("miss_ack", 64'(acks), 64'(0));
    end else if (oor) begin
      check("oor_lat", 64'(lat), 64'(2));
      check("oor_acc", 64'(acc), 64'(0));
`ifdef STORAGE_WB_ERR_EN
      check("oor_err", 64'(errs), 64'(1));
      check("oor_ack", 64'(acks), 64'(0));
      check("oor_dat", 64'(rd), 64'(exp_dat));
`else
      check("oor_ack", 64'(acks), 64'(1));
      if (!we) exp_dat = '0;
      check("oor_dat", 64'(rd), 64'(exp_dat));
`endif
    end else begin
      exp_ena = '1;
      exp_ena[bank] = 1'b0;
      exp_wen = we ? exp_ena : '1;
      exp_mask = '0;
      if (we) exp_mask[bank*4 +: 4] = sel;
      check("lat", 64'(lat), 64'(we ? 2 : 3));
      check("acc", 64'(acc), 64'(1));
      check("ack", 64'(acks), 64'(1));
      check("ena", 64'(last_ena), 64'(exp_ena));
      check("wen", 64'(last_wen), 64'(exp_wen));
      check("mask", 64'(last_mask), 64'(exp_mask));
      check("addr", 64'(last_addr), 64'(word));
      if (we) begin
        check("wdata", 64'(last_wdata), 64'(dat));
        for (int k = 0; k < 4; k++)
          if (sel[k]) ref_mem[bank][word][k*8 +: 8] = dat[k*8 +: 8];
      end else exp_dat = ref_mem[bank][word];
      check(we ? "dat_hold" : "rdata", 64'(rd), 64'(exp_dat));
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int a0, k0;
    logic [31:0] adr;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = '0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(wb.wbs_ack_o), 64'(0));
    check("rst_dat", 64'(wb.wbs_dat_o), 64'(0));
    check("rst_ena", 64'(mem_ena), 64'(2'b11));
    check("rst_wen", 64'(mem_wen), 64'(2'b11));
    check("rst_mask", 64'(mem_wen_mask), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    rst = 1'b0;
    run(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0);
    run(1'b1, 4'hF, 32'h3000_0804, 32'h1234_5678, 1'b0);
    run(1'b0, 4'hF, 32'h3000_0804, 32'h0, 1'b0);
    run(1'b1, 4'hF, 32'h3000_0008, 32'hA1B2_C3D4, 1'b1);
    run(1'b1, 4'b0100, 32'h3000_0008, 32'h55EE_6677, 1'b1);
    run(1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b1);
    check("byte2_only", 64'(exp_dat), 64'(32'hA1EE_C3D4));
    run(1'b1, 4'h0, 32'h3000_0008, 32'hFFFF_FFFF, 1'b0);
    run(1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b0);
    run(1'b0, 4'hF, 32'h3000_1000, 32'h0, 1'b0);
    run(1'b1, 4'hF, 32'h3000_1000, 32'h0BAD_0BAD, 1'b0);
    run(1'b0, 4'hF, 32'h4000_0000, 32'h0, 1'b0);
    run(1'b0, 4'hF, 32'h3000_0004, 32'h0, 1'b0);
    // cyc drops while the read is waiting on SRAM data
    a0 = acc_cnt; k0 = ack_cnt;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = 32'h3000_0804;
    repeat (2) @(posedge clk);
    #1;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drop_ack", 64'(ack_cnt - k0), 64'(0));
    check("drop_acc", 64'(acc_cnt - a0), 64'(1));
    check("drop_dat", 64'(wb.wbs_dat_o), 64'(exp_dat));
    run(1'b0, 4'hF, 32'h3000_0804, 32'h0, 1'b0);
    // reset asserted while a read sits in ACCESS
    k0 = ack_cnt;
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0; wb.wbs_adr_i = 32'h3000_0004;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_ack", 64'(ack_cnt - k0), 64'(0));
    check("rst_mid_ena", 64'(mem_ena), 64'(2'b11));
    check("rst_mid_dat", 64'(wb.wbs_dat_o), 64'(0));
    exp_dat = '0;
    for (int i = 0; i < 150; i++) begin
      adr = {18'h0C000, 3'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), 2'($urandom)};
      case ($urandom_range(0, 9))
        0: adr[13:11] = 3'($urandom_range(2, 7));
        1: adr[31:14] = 18'($urandom);
        default: ;
      endcase
      run(1'($urandom_range(0, 1)), 4'($urandom), adr, 32'($urandom), 1'($urandom_range(0, 1)));
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
